// File: rtl/fdivsqrtpostprocseq.sv
// Resolves the divider's redundant residual one CHUNK slice per cycle, then picks U or UM and
// a sticky bit; latency NCH cycles, holds the result in DONE until OutReady, InReady only in IDLE.
module fdivsqrtpostprocseq #(
  parameter int DIVb  = 64,
  parameter int CHUNK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            InValid,
  output logic            InReady,
  input  logic [DIVb+3:0] WS,
  input  logic [DIVb+3:0] WC,
  input  logic [DIVb:0]   U,
  input  logic [DIVb:0]   UM,
  input  logic            Abort,
  output logic            OutValid,
  input  logic            OutReady,
  output logic [DIVb:0]   Q,
  output logic            Sticky,
  output logic            Neg
);

  localparam int W     = DIVb + 4;
  localparam int NCH   = (W + CHUNK - 1) / CHUNK;
  localparam int PW    = NCH * CHUNK;
  localparam int LASTW = W - (NCH - 1) * CHUNK;
  localparam int KW    = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [KW-1:0]    KLAST    = KW'(NCH - 1);
  localparam logic [CHUNK-1:0] LASTMASK = {CHUNK{1'b1}} >> (CHUNK - LASTW);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t          state_q;
  logic [PW-1:0]   ws_q, wc_q;
  logic [DIVb:0]   u_q, um_q, q_q;
  logic [KW-1:0]   k_q;
  logic            carry_q, zero_q, sticky_q, neg_q;

  int              base;
  logic            last_slice;
  logic [CHUNK:0]  slice_sum;
  logic [CHUNK-1:0] slice_s;
  logic            zero_d;
  logic            neg_d;

  // The residual is zero-padded to NCH full slices; the last slice is masked back to its
  // true width so carries into the padding never reach the zero test or the sign bit.
  always_comb begin
    base       = int'(k_q) * CHUNK;
    last_slice = (k_q == KLAST);
    slice_sum  = {1'b0, ws_q[base +: CHUNK]} + {1'b0, wc_q[base +: CHUNK]}
               + {{CHUNK{1'b0}}, carry_q};
    slice_s    = slice_sum[CHUNK-1:0] & (last_slice ? LASTMASK : {CHUNK{1'b1}});
    zero_d     = zero_q & (slice_s == '0);
    neg_d      = slice_s[LASTW-1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      ws_q     <= '0;
      wc_q     <= '0;
      u_q      <= '0;
      um_q     <= '0;
      k_q      <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      q_q      <= '0;
      sticky_q <= 1'b0;
      neg_q    <= 1'b0;
    end else if (Abort) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (InValid) begin
            ws_q    <= PW'(WS);
            wc_q    <= PW'(WC);
            u_q     <= U;
            um_q    <= UM;
            k_q     <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b1;
            state_q <= ADD;
          end
        end
        ADD: begin
          carry_q <= slice_sum[CHUNK];
          zero_q  <= zero_d;
          k_q     <= k_q + 1'b1;
          if (last_slice) begin
            neg_q    <= neg_d;
            sticky_q <= ~zero_d;
            q_q      <= neg_d ? um_q : u_q;
            state_q  <= DONE;
          end
        end
        DONE: begin
          if (OutReady) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign InReady  = (state_q == IDLE);
  assign OutValid = (state_q == DONE);
  assign Q        = q_q;
  assign Sticky   = sticky_q;
  assign Neg      = neg_q;

endmodule

// File: tb/tb_fdivsqrtpostprocseq.sv
// Scoreboard bench: expected results come from plain modular addition of the residual.
module tb_fdivsqrtpostprocseq;

  localparam int DIVB = 64;
  localparam int W    = DIVB + 4;
  localparam int NCH  = 5;

  typedef struct packed {
    logic [DIVB:0] q;
    logic          sticky;
    logic          neg;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            InValid;
  logic            InReady;
  logic [W-1:0]    WS, WC;
  logic [DIVB:0]   U, UM;
  logic            Abort;
  logic            OutValid;
  logic            OutReady;
  logic [DIVB:0]   Q;
  logic            Sticky;
  logic            Neg;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  bit   rdy_rand  = 1'b0;
  bit   rdy_force = 1'b1;

  fdivsqrtpostprocseq #(.DIVb(DIVB), .CHUNK(16)) dut (
    .clk(clk), .reset(reset), .InValid(InValid), .InReady(InReady),
    .WS(WS), .WC(WC), .U(U), .UM(UM), .Abort(Abort),
    .OutValid(OutValid), .OutReady(OutReady), .Q(Q), .Sticky(Sticky), .Neg(Neg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: the residual is just (WS + WC) mod 2^W; its sign and zero-ness decide the rest.
  function automatic exp_t model(input logic [W-1:0] ws, input logic [W-1:0] wc,
                                 input logic [DIVB:0] u, input logic [DIVB:0] um);
    exp_t        e;
    logic [W-1:0] s;
    s        = ws + wc;
    e.neg    = s[W-1];
    e.sticky = (s != '0);
    e.q      = e.neg ? um : u;
    return e;
  endfunction

  always @(posedge clk) begin
    #1;
    OutReady = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
  end

  always @(negedge clk) begin
    if (!reset && OutValid && OutReady) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 128'(1), 128'(0));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("q",      128'(Q),      128'(e.q));
        chk("sticky", 128'(Sticky), 128'(e.sticky));
        chk("neg",    128'(Neg),    128'(e.neg));
      end
    end
  end

  // Presents one input and returns just after the capture edge.
  task automatic send(input logic [W-1:0] ws, input logic [W-1:0] wc,
                      input logic [DIVB:0] u, input logic [DIVB:0] um, input bit push);
    int n;
    @(negedge clk);
    WS = ws; WC = wc; U = u; UM = um; InValid = 1'b1;
    n = 0;
    while (!InReady && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!InReady) chk("send_timeout", 128'(0), 128'(1));
    if (push) exp_q.push_back(model(ws, wc, u, um));
    @(posedge clk);
    #1 InValid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!OutValid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !InReady) && n < 1000) begin
      @(posedge clk);
      n++;
    end
    chk("drain", 128'(exp_q.size()), 128'(0));
  endtask

  logic [DIVB:0] u0;
  logic [W-1:0]  ones;

  initial begin
    int          lat;
    logic [DIVB:0] q0;
    logic        s0, n0;
    bit          saw;
    u0   = {1'b1, 64'h8000_0000_0000_0000};
    ones = '1;
    reset = 1'b1; InValid = 1'b0; Abort = 1'b0;
    WS = '0; WC = '0; U = '0; UM = '0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_inready",  128'(InReady),  128'(1));
    chk("rst_outvalid", 128'(OutValid), 128'(0));
    chk("rst_q",        128'(Q),        128'(0));
    chk("rst_sticky",   128'(Sticky),   128'(0));
    chk("rst_neg",      128'(Neg),      128'(0));
    @(negedge clk) reset = 1'b0;

    // exact result plus latency
    send(W'(1), ones, u0, u0 - 1'b1, 1'b1);
    wait_out(lat);
    chk("latency", 128'(lat), 128'(NCH));
    wait_drain();
    // negative residual
    send(ones, '0, u0, u0 - 1'b1, 1'b1);
    // carry into second slice, then ripple through four slices
    send(W'(68'h0_0000_0000_0000_FFFF), W'(1), u0, u0 - 1'b1, 1'b1);
    send(W'(68'h0_FFFF_FFFF_FFFF_FFFF), W'(1), u0, u0 - 1'b1, 1'b1);
    // carry into the truncated top slice flips the sign
    send(W'(68'h7_FFFF_FFFF_FFFF_FFFF), W'(1), u0, u0 - 1'b1, 1'b1);
    wait_drain();

    // backpressure
    rdy_force = 1'b0;
    @(posedge clk); #2;
    send(ones, W'(5), 65'h0_1234_5678_9ABC_DEF0, 65'h0_1234_5678_9ABC_DEEF, 1'b1);
    wait_out(lat);
    chk("bp_valid", 128'(OutValid), 128'(1));
    q0 = Q; s0 = Sticky; n0 = Neg;
    repeat (3) begin
      @(negedge clk);
      chk("bp_q_stable",   128'({Q, Sticky, Neg}), 128'({q0, s0, n0}));
      chk("bp_inready",    128'(InReady),          128'(0));
      chk("bp_valid_hold", 128'(OutValid),         128'(1));
    end
    rdy_force = 1'b1;
    @(posedge clk); #2;
    @(posedge clk); #1;
    chk("bp_idle", 128'(InReady), 128'(1));
    send(W'(3), ones, u0, u0 - 1'b1, 1'b1);
    wait_drain();

    // abort mid-ADD
    send(W'(68'h1_0000_0000_0000_0000), W'(7), u0, u0 - 1'b1, 1'b0);
    @(posedge clk); #1 Abort = 1'b1;
    @(posedge clk); #1 Abort = 1'b0;
    chk("abort_inready",  128'(InReady),  128'(1));
    chk("abort_outvalid", 128'(OutValid), 128'(0));
    saw = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (OutValid) saw = 1'b1;
    end
    chk("abort_no_valid", 128'(saw), 128'(0));
    send(W'(68'h2_0000_0000_0000_0001), ones, u0, u0 - 1'b1, 1'b1);
    wait_drain();

    // randomized traffic with random backpressure
    rdy_rand = 1'b1;
    for (int i = 0; i < 40; i++) begin
      logic [95:0]   r96;
      logic [W-1:0]  ws, wc;
      logic [DIVB:0] u;
      r96 = {$urandom, $urandom, $urandom};
      ws  = r96[W-1:0];
      r96 = {$urandom, $urandom, $urandom};
      u   = r96[DIVB:0];
      case ($urandom_range(0, 3))
        0: begin r96 = {$urandom, $urandom, $urandom}; wc = r96[W-1:0]; end
        1: wc = -ws;
        2: wc = -ws - 1'b1;
        default: wc = -ws + W'($urandom_range(1, 300));
      endcase
      send(ws, wc, u, u - 1'b1, 1'b1);
    end
    wait_drain();

    // async reset while in DONE
    rdy_rand = 1'b0; rdy_force = 1'b0;
    @(posedge clk); #2;
    send(ones, W'(2), u0, u0 - 1'b1, 1'b0);
    wait_out(lat);
    chk("pre_reset_valid", 128'(OutValid), 128'(1));
    @(negedge clk); #2 reset = 1'b1;
    #1;
    chk("arst_outvalid", 128'(OutValid), 128'(0));
    chk("arst_q",        128'(Q),        128'(0));
    chk("arst_sticky",   128'(Sticky),   128'(0));
    chk("arst_neg",      128'(Neg),      128'(0));
    chk("arst_inready",  128'(InReady),  128'(1));
    @(negedge clk) reset = 1'b0;
    rdy_force = 1'b1;
    send(W'(9), ones, u0, u0 - 1'b1, 1'b1);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
